// File: rtl/core_exwb_if.sv
// Execute/writeback stage bus: instruction offer, load/mul-div returns, register write and status.
// The slave side is the stage itself; the master side is the surrounding pipeline.
interface core_exwb_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
);
    logic               id_valid;
    logic [2:0]         id_class;
    logic [RADDR_W-1:0] id_regd;
    logic [XLEN-1:0]    id_pc;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    rega_data;
    logic               ex_halt;
    logic               ex_ready;
    logic               mau_valid;
    logic [XLEN-1:0]    mau_data;
    logic               md_start;
    logic               md_done;
    logic [XLEN-1:0]    md_result;
    logic               wb;
    logic [RADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]    wb_data;
    logic [XLEN-1:0]    ex_pc;
    logic [CNT_W-1:0]   retire_cnt;

    modport master (
        output id_valid, id_class, id_regd, id_pc, alu_result, rega_data, ex_halt,
        output mau_valid, mau_data, md_done, md_result,
        input  ex_ready, md_start, wb, wb_addr, wb_data, ex_pc, retire_cnt
    );

    modport slave (
        input  id_valid, id_class, id_regd, id_pc, alu_result, rega_data, ex_halt,
        input  mau_valid, mau_data, md_done, md_result,
        output ex_ready, md_start, wb, wb_addr, wb_data, ex_pc, retire_cnt
    );
endinterface

// File: rtl/core_exwb.sv
// Execute/writeback stage: ALU/MOV/NOP retire 1 cycle after acceptance, LD/MULDIV 1 cycle after their return.
// Backpressure: ex_ready drops while a load or mul/div is outstanding, or while ex_halt is high.
module core_exwb #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 4,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 0
) (
    input  logic        clk,
    input  logic        rst,
    core_exwb_if.slave  bus
);
    localparam logic [2:0] CLS_ALU    = 3'd1;
    localparam logic [2:0] CLS_MOV    = 3'd2;
    localparam logic [2:0] CLS_LD     = 3'd3;
    localparam logic [2:0] CLS_MULDIV = 3'd4;

    typedef enum logic [1:0] {IDLE, WAIT_LD, WAIT_MD} state_t;

    state_t state;
    logic   ready;
    logic   accept;

    assign ready        = !rst && (state == IDLE) && !bus.ex_halt;
    assign accept       = bus.id_valid && ready;
    assign bus.ex_ready = ready;

    // A hardwired register 0 still retires normally; only the write strobe is suppressed.
    function automatic logic wr_ok(input logic [RADDR_W-1:0] addr);
        return !((ZERO_REG != 0) && (addr == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.wb         <= 1'b0;
            bus.wb_addr    <= '0;
            bus.wb_data    <= '0;
            bus.ex_pc      <= '0;
            bus.md_start   <= 1'b0;
            bus.retire_cnt <= '0;
        end else begin
            bus.wb       <= 1'b0;
            bus.md_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.wb_addr <= bus.id_regd;
                        bus.ex_pc   <= bus.id_pc;
                        case (bus.id_class)
                            CLS_ALU: begin
                                bus.wb         <= wr_ok(bus.id_regd);
                                bus.wb_data    <= bus.alu_result;
                                bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
                            end
                            CLS_MOV: begin
                                bus.wb         <= wr_ok(bus.id_regd);
                                bus.wb_data    <= bus.rega_data;
                                bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
                            end
                            CLS_LD: begin
                                state <= WAIT_LD;
                            end
                            CLS_MULDIV: begin
                                state        <= WAIT_MD;
                                bus.md_start <= 1'b1;
                            end
                            default: begin
                                bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
                            end
                        endcase
                    end
                end
                WAIT_LD: begin
                    if (bus.mau_valid) begin
                        state          <= IDLE;
                        bus.wb         <= wr_ok(bus.wb_addr);
                        bus.wb_data    <= bus.mau_data;
                        bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
                    end
                end
                WAIT_MD: begin
                    // md_done may already arrive while md_start is still high.
                    if (bus.md_done) begin
                        state          <= IDLE;
                        bus.wb         <= wr_ok(bus.wb_addr);
                        bus.wb_data    <= bus.md_result;
                        bus.retire_cnt <= bus.retire_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_exwb.sv
// Bench for core_exwb: directed vector table, hand sequences, and random traffic against a reference model.
module tb_core_exwb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_valid, i_halt, i_mau_v, i_md_done;
    logic [2:0]  i_class;
    logic [3:0]  i_regd;
    logic [31:0] i_pc, i_alu, i_rega, i_mau_d, i_md_res;

    core_exwb_if #(.XLEN(32), .RADDR_W(4), .CNT_W(16)) if0 ();
    core_exwb_if #(.XLEN(32), .RADDR_W(4), .CNT_W(4))  if1 ();

    assign if0.id_valid = i_valid;   assign if1.id_valid = i_valid;
    assign if0.id_class = i_class;   assign if1.id_class = i_class;
    assign if0.id_regd = i_regd;     assign if1.id_regd = i_regd;
    assign if0.id_pc = i_pc;         assign if1.id_pc = i_pc;
    assign if0.alu_result = i_alu;   assign if1.alu_result = i_alu;
    assign if0.rega_data = i_rega;   assign if1.rega_data = i_rega;
    assign if0.ex_halt = i_halt;     assign if1.ex_halt = i_halt;
    assign if0.mau_valid = i_mau_v;  assign if1.mau_valid = i_mau_v;
    assign if0.mau_data = i_mau_d;   assign if1.mau_data = i_mau_d;
    assign if0.md_done = i_md_done;  assign if1.md_done = i_md_done;
    assign if0.md_result = i_md_res; assign if1.md_result = i_md_res;

    core_exwb #(.XLEN(32), .RADDR_W(4), .CNT_W(16), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    core_exwb #(.XLEN(32), .RADDR_W(4), .CNT_W(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding "pending" kind per instance (0 none, 1 load, 2 mul/div).
    int          m_pend[2];
    logic        m_wb[2], m_ms[2];
    logic [3:0]  m_addr[2];
    logic [31:0] m_data[2], m_pc[2];
    int unsigned m_cnt[2];

    function automatic int unsigned cnt_mod(input int i);
        return (i == 0) ? 32'd65536 : 32'd16;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit          retire, writes;
            logic [31:0] d;
            retire = 0; writes = 0; d = '0;
            if (rst) begin
                m_pend[i] = 0; m_wb[i] = 0; m_ms[i] = 0; m_addr[i] = '0;
                m_data[i] = '0; m_pc[i] = '0; m_cnt[i] = 0;
                continue;
            end
            m_ms[i] = 0;
            if (m_pend[i] == 0 && i_valid && !i_halt) begin
                m_addr[i] = i_regd;
                m_pc[i]   = i_pc;
                if (i_class == 3'd1)      begin retire = 1; writes = 1; d = i_alu;  end
                else if (i_class == 3'd2) begin retire = 1; writes = 1; d = i_rega; end
                else if (i_class == 3'd3) m_pend[i] = 1;
                else if (i_class == 3'd4) begin m_pend[i] = 2; m_ms[i] = 1; end
                else retire = 1;
            end else if (m_pend[i] == 1 && i_mau_v) begin
                m_pend[i] = 0; retire = 1; writes = 1; d = i_mau_d;
            end else if (m_pend[i] == 2 && i_md_done) begin
                m_pend[i] = 0; retire = 1; writes = 1; d = i_md_res;
            end
            m_wb[i] = writes && !(i == 1 && m_addr[i] == 4'd0);
            if (writes) m_data[i] = d;
            if (retire) m_cnt[i] = (m_cnt[i] + 1) % cnt_mod(i);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            logic        a_rdy, a_wb, a_ms;
            logic [31:0] a_addr, a_data, a_pc, a_cnt;
            a_rdy  = (i == 0) ? if0.ex_ready : if1.ex_ready;
            a_wb   = (i == 0) ? if0.wb : if1.wb;
            a_ms   = (i == 0) ? if0.md_start : if1.md_start;
            a_addr = (i == 0) ? 32'(if0.wb_addr) : 32'(if1.wb_addr);
            a_data = (i == 0) ? if0.wb_data : if1.wb_data;
            a_pc   = (i == 0) ? if0.ex_pc : if1.ex_pc;
            a_cnt  = (i == 0) ? 32'(if0.retire_cnt) : 32'(if1.retire_cnt);
            chk($sformatf("ex_ready[%0d]", i), 32'(a_rdy), 32'(!rst && m_pend[i] == 0 && !i_halt));
            chk($sformatf("wb[%0d]", i), 32'(a_wb), 32'(m_wb[i]));
            chk($sformatf("md_start[%0d]", i), 32'(a_ms), 32'(m_ms[i]));
            chk($sformatf("wb_addr[%0d]", i), a_addr, 32'(m_addr[i]));
            chk($sformatf("ex_pc[%0d]", i), a_pc, m_pc[i]);
            chk($sformatf("retire_cnt[%0d]", i), a_cnt, m_cnt[i]);
            if (m_wb[i]) chk($sformatf("wb_data[%0d]", i), a_data, m_data[i]);
        end
    endtask

    task automatic finish_cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic idle_in();
        i_valid = 0; i_class = '0; i_regd = '0; i_pc = '0; i_alu = '0; i_rega = '0;
        i_halt = 0; i_mau_v = 0; i_mau_d = '0; i_md_done = 0; i_md_res = '0;
    endtask

    task automatic offer(input logic [2:0] cls, input logic [3:0] regd, input logic [31:0] pc,
                         input logic [31:0] alu);
        idle_in();
        i_valid = 1; i_class = cls; i_regd = regd; i_pc = pc; i_alu = alu;
    endtask

    typedef struct {
        logic [31:0] v, cls, regd, pc, alu, rega, halt, mv, md, mdd, mres;
        logic [31:0] e_rdy, e_wb, e_addr, e_data, e_ms, e_pc, e_cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        //           v cls rg pc      alu     rega  h mv md            mdd mres   rdy wb addr data         ms pc      cnt
        tbl[0]  = '{1, 1, 3, 'h100, 'h1234, 0,    0, 0, 0,            0, 0,     1, 0, 0, 0,            0, 0,      0};
        tbl[1]  = '{1, 2, 5, 'h104, 0,      'hAA, 0, 0, 0,            0, 0,     1, 1, 3, 'h1234,       0, 'h100,  1};
        tbl[2]  = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     1, 1, 5, 'hAA,         0, 'h104,  2};
        tbl[3]  = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     1, 0, 5, 0,            0, 'h104,  2};
        tbl[4]  = '{1, 3, 7, 'h108, 0,      0,    0, 0, 0,            0, 0,     1, 0, 5, 0,            0, 'h104,  2};
        tbl[5]  = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     0, 0, 7, 0,            0, 'h108,  2};
        tbl[6]  = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     0, 0, 7, 0,            0, 'h108,  2};
        tbl[7]  = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     0, 0, 7, 0,            0, 'h108,  2};
        tbl[8]  = '{0, 0, 0, 0,     0,      0,    0, 1, 'hDEADBEEF,   0, 0,     0, 0, 7, 0,            0, 'h108,  2};
        tbl[9]  = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     1, 1, 7, 'hDEADBEEF,   0, 'h108,  3};
        tbl[10] = '{1, 4, 9, 'h10C, 0,      0,    0, 0, 0,            0, 0,     1, 0, 7, 0,            0, 'h108,  3};
        tbl[11] = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            1, 'h10,  0, 0, 9, 0,            1, 'h10C,  3};
        tbl[12] = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     1, 1, 9, 'h10,         0, 'h10C,  4};
        tbl[13] = '{1, 1, 2, 'h200, 'h999,  0,    1, 0, 0,            0, 0,     0, 0, 9, 0,            0, 'h10C,  4};
        tbl[14] = '{0, 0, 0, 0,     0,      0,    0, 0, 0,            0, 0,     1, 0, 9, 0,            0, 'h10C,  4};

        idle_in();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_step();
        cycle();              // outputs held at reset values, ex_ready low
        rst = 0;

        for (int r = 0; r < 15; r++) begin
            i_valid = tbl[r].v[0];     i_class = tbl[r].cls[2:0]; i_regd = tbl[r].regd[3:0];
            i_pc = tbl[r].pc;          i_alu = tbl[r].alu;        i_rega = tbl[r].rega;
            i_halt = tbl[r].halt[0];   i_mau_v = tbl[r].mv[0];    i_mau_d = tbl[r].md;
            i_md_done = tbl[r].mdd[0]; i_md_res = tbl[r].mres;
            @(negedge clk);
            chk($sformatf("tbl%0d ex_ready", r), 32'(if0.ex_ready), tbl[r].e_rdy);
            chk($sformatf("tbl%0d wb", r), 32'(if0.wb), tbl[r].e_wb);
            chk($sformatf("tbl%0d wb_addr", r), 32'(if0.wb_addr), tbl[r].e_addr);
            chk($sformatf("tbl%0d md_start", r), 32'(if0.md_start), tbl[r].e_ms);
            chk($sformatf("tbl%0d ex_pc", r), if0.ex_pc, tbl[r].e_pc);
            chk($sformatf("tbl%0d retire_cnt", r), 32'(if0.retire_cnt), tbl[r].e_cnt);
            if (tbl[r].e_wb != 0) chk($sformatf("tbl%0d wb_data", r), if0.wb_data, tbl[r].e_data);
            finish_cycle();
        end

        // 17 NOP retires wrap the 4-bit counter to 1
        idle_in();
        rst = 1;
        cycle();
        rst = 0;
        for (int n = 0; n < 17; n++) begin
            offer(3'd0, 4'(n), 32'h300 + 32'(n), 32'h0);
            cycle();
        end
        idle_in();
        @(negedge clk);
        chk("nop17 retire_cnt cnt4", 32'(if1.retire_cnt), 32'd1);
        chk("nop17 retire_cnt cnt16", 32'(if0.retire_cnt), 32'd17);
        finish_cycle();

        // Write to hardwired register 0 is suppressed but still retires
        offer(3'd1, 4'd0, 32'h400, 32'h55);
        cycle();
        idle_in();
        @(negedge clk);
        chk("zero_reg wb", 32'(if1.wb), 32'd0);
        chk("zero_reg retire_cnt", 32'(if1.retire_cnt), 32'd2);
        chk("reg0 writable wb", 32'(if0.wb), 32'd1);
        finish_cycle();

        // Reset mid-load abandons it; a late mau_valid is ignored
        offer(3'd3, 4'd6, 32'h500, 32'h0);
        cycle();
        idle_in();
        repeat (2) cycle();
        rst = 1;
        cycle();
        rst = 0;
        i_mau_v = 1; i_mau_d = 32'h77;
        cycle();
        idle_in();
        @(negedge clk);
        chk("rst_ld wb", 32'(if0.wb), 32'd0);
        chk("rst_ld wb_addr", 32'(if0.wb_addr), 32'd0);
        chk("rst_ld wb_data", if0.wb_data, 32'd0);
        chk("rst_ld ex_pc", if0.ex_pc, 32'd0);
        chk("rst_ld retire_cnt", 32'(if0.retire_cnt), 32'd0);
        chk("rst_ld md_start", 32'(if0.md_start), 32'd0);
        chk("rst_ld ex_ready", 32'(if0.ex_ready), 32'd1);
        finish_cycle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 63) == 0);
            i_valid   = ($urandom_range(0, 9) < 7);
            i_class   = 3'($urandom_range(0, 7));
            i_regd    = 4'($urandom_range(0, 15));
            i_pc      = $urandom;
            i_alu     = $urandom;
            i_rega    = $urandom;
            i_halt    = ($urandom_range(0, 4) == 0);
            i_mau_v   = ($urandom_range(0, 2) == 0);
            i_mau_d   = $urandom;
            i_md_done = ($urandom_range(0, 2) == 0);
            i_md_res  = $urandom;
            cycle();
        end
        rst = 0;
        idle_in();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/core_exwb.md
CORE_EXWB -- requirements
Module: core_exwb

Interface
REQ-001 SHALL take parameter XLEN, default 32: datapath width.
REQ-002 SHALL take parameter RADDR_W, default 4: register address width.
REQ-003 SHALL take parameter CNT_W, default 16: retire counter width.
REQ-004 SHALL take parameter ZERO_REG, default 0: if 1, register 0 is hardwired and never written.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port id_valid  in  1  instruction offered.
REQ-008 SHALL have port id_class  in  3  0=NOP, 1=ALU, 2=MOV, 3=LD, 4=MULDIV, 5-7=NOP.
REQ-009 SHALL have port id_regd  in  RADDR_W  destination register.
REQ-010 SHALL have port id_pc  in  XLEN  instruction PC.
REQ-011 SHALL have port alu_result  in  XLEN  ALU result for the offered instruction.
REQ-012 SHALL have port rega_data  in  XLEN  operand A for MOV.
REQ-013 SHALL have port ex_halt  in  1  blocks acceptance.
REQ-014 SHALL have port ex_ready  out  1  stage accepts this cycle.
REQ-015 SHALL have port mau_valid  in  1 and mau_data  in  XLEN: load return.
REQ-016 SHALL have port md_start  out  1 and md_done  in  1 and md_result  in  XLEN: mul/div unit handshake.
REQ-017 SHALL have ports wb  out  1, wb_addr  out  RADDR_W, wb_data  out  XLEN: register write.
REQ-018 SHALL have ports ex_pc  out  XLEN  PC of last accepted instruction; retire_cnt  out  CNT_W.

Function
REQ-019 SHALL implement states IDLE, WAIT_LD, WAIT_MD.
REQ-020 SHALL drive ex_ready = (state==IDLE) && !ex_halt, combinationally.
REQ-021 SHALL accept an instruction when id_valid && ex_ready, capturing id_regd, id_pc, alu_result, rega_data.
REQ-022 SHALL, on accepting ALU or MOV, assert wb for exactly the following cycle with wb_data = captured alu_result or rega_data respectively; state stays IDLE, so back-to-back acceptance is allowed (1 instruction/cycle).
REQ-023 SHALL, on accepting LD, enter WAIT_LD; in WAIT_LD a cycle with mau_valid=1 causes wb=1, wb_data=mau_data in the next cycle and a return to IDLE.
REQ-024 SHALL, on accepting MULDIV, pulse md_start for exactly one cycle (the cycle after acceptance) and enter WAIT_MD; md_done=1 (including in the same cycle md_start is high) causes wb=1, wb_data=md_result in the next cycle and a return to IDLE.
REQ-025 SHALL ignore mau_valid outside WAIT_LD and md_done outside WAIT_MD.
REQ-026 SHALL, on NOP classes, produce no wb and remain IDLE.
REQ-027 SHALL drive wb_addr as the captured id_regd, holding it until the next acceptance.
REQ-028 SHALL, when ZERO_REG=1 and the captured destination is 0, force wb=0 while otherwise completing normally, including state transitions and retire count.
REQ-029 SHALL update ex_pc on every acceptance.
REQ-030 SHALL increment retire_cnt by 1, modulo 2^CNT_W, in the cycle an instruction completes: ALU/MOV/NOP one cycle after acceptance, LD/MULDIV with their wb cycle.
REQ-031 SHALL NOT let ex_halt abort or delay WAIT_LD or WAIT_MD; it only gates acceptance.
REQ-032 SHALL register wb, wb_addr, wb_data, ex_pc, md_start and retire_cnt, with no combinational input-to-output path except ex_ready.

Reset
REQ-033 SHALL, while rst=1, force state IDLE, wb=0, wb_addr=0, wb_data=0, ex_pc=0, md_start=0 and retire_cnt=0; ex_ready=0 during reset.
REQ-034 SHALL abandon any pending load or mul/div when rst rises mid-operation; a later mau_valid or md_done then arrives in IDLE and is ignored.

Verification
REQ-035 SHALL be checked by bench: ALU regd=3, alu_result=0x1234 then MOV regd=5, rega=0xAA on consecutive cycles -> wb pulses on the next two cycles (3/0x1234, 5/0xAA); retire_cnt=2.
REQ-036 SHALL be checked by bench: LD regd=7, mau_valid after 4 cycles with mau_data=0xDEADBEEF -> ex_ready=0 for 4 cycles, then wb=1, 7/0xDEADBEEF, then ex_ready=1.
REQ-037 SHALL be checked by bench: MULDIV, md_done in the same cycle as md_start, md_result=0x10 -> md_start single-cycle, wb next cycle with 0x10.
REQ-038 SHALL be checked by bench: ZERO_REG=1, ALU regd=0 -> wb stays 0, retire_cnt increments.
REQ-039 SHALL be checked by bench: CNT_W=4, 17 NOP retires -> retire_cnt=1; ex_halt=1 with id_valid=1 -> no acceptance, ex_pc unchanged.
REQ-040 SHALL be checked by bench: rst asserted during WAIT_LD, then mau_valid -> no wb, all outputs 0, state IDLE.
